quadrature_position_decoder: RTL and testbench
==============================================

// Module: quadrature_position_decoder
// PURPOSE
//  Feedback-side companion to the bipolar micro-stepper. Samples a motor shaft's quadrature encoder (A/B/index), filters
//  glitches, decodes 4x edges into a 32-bit signed position, and measures the inter-edge period for velocity.
//  Sits beside the stepper inside the wishbone stepper slave; its outputs are register-readable and feed closed-loop checks.
// PARAMETERS
//  FILTER_DEPTH    4           consecutive identical synced samples required to accept a new A/B/index level (>=1)
//  TIMEOUT_CYCLES  32'd1000000 inter-edge cycle count at which the period counter saturates and o_stalled asserts
// PORTS
//  clk               in   1   system clock
//  rst               in   1   synchronous, active-high reset
//  i_enc_a           in   1   encoder channel A, asynchronous
//  i_enc_b           in   1   encoder channel B, asynchronous
//  i_enc_index       in   1   encoder index, asynchronous
//  i_enable          in   1   1 = count edges; 0 = position frozen, filters keep tracking
//  i_invert_dir      in   1   1 = negate count sign
//  i_load            in   1   one-cycle pulse: position <= i_load_position
//  i_load_position   in   32  value for i_load
//  i_clear           in   1   one-cycle pulse: clears o_error and o_index_seen
//  o_position        out  32  current count, modulo 2^32
//  o_direction       out  1   direction of last valid edge, 1 = positive
//  o_step_strobe     out  1   one-cycle pulse per counted edge
//  o_step_period     out  32  clk cycles between the last two same-direction edges
//  o_period_valid    out  1   o_step_period is meaningful
//  o_stalled         out  1   no valid edge for TIMEOUT_CYCLES
//  o_index_position  out  32  position latched on filtered index rising edge
//  o_index_seen      out  1   sticky, set on index rising edge
//  o_error           out  1   sticky, set on illegal transition (A and B change together)
// BEHAVIOUR
//  - Reset: all outputs 0; filtered A/B/index 0; FSM -> PRIME.
//  - Each input passes a 2-FF synchronizer, then a filter. The filtered level changes only after FILTER_DEPTH consecutive
//    synced samples differ from it. Pin change -> filtered change = 2+FILTER_DEPTH cycles; outputs update 1 cycle later.
//  - FSM PRIME: after reset, wait until A, B and index are each stable FILTER_DEPTH samples. Load the filtered state with no
//    count, error, index event or strobe, then go to RUN. Only rst re-enters PRIME.
//  - FSM RUN: decodes each filtered {A,B} change.
//    - Forward sequence 00->10->11->01->00 = +1; reverse = -1; sign negated when i_invert_dir=1.
//    - Both bits changed: o_error<=1, no count, no strobe, o_direction unchanged.
//  - A valid edge with i_enable=1 does all of: position += +/-1 (wraps 0xFFFFFFFF+1 = 0, 0-1 = 0xFFFFFFFF);
//    o_step_strobe=1 for that cycle; o_direction updated.
//  - i_enable=0: position, strobe, period and index latching are all suppressed. Period counter held at 0,
//    o_period_valid<=0. Filter and decode state keep tracking, so re-enable causes no false count.
//  - i_load wins over a same-cycle edge: position <= i_load_position. That edge still strobes and updates direction.
//  - Period counter: increments each cycle, saturates at TIMEOUT_CYCLES, cleared to 0 on every valid counted edge.
//    - On an edge: o_step_period <= counter+1 and o_period_valid <= 1, but only if (a) the counter was not saturated and
//      (b) the direction equals the previous edge's direction.
//    - Otherwise (reversal, saturated, or first edge after reset/enable): o_period_valid <= 0, o_step_period is held.
//  - o_stalled = 1 while the counter is saturated; saturation also drops o_period_valid. The next valid edge clears
//    o_stalled, but o_period_valid stays 0 until the edge after that.
//  - Index: a filtered rising edge in RUN with i_enable=1 sets o_index_seen and latches o_index_position with the
//    post-update position of that same cycle (load value if i_load).
//  - i_clear clears o_error and o_index_seen. A same-cycle set wins over clear.
// TESTING (FILTER_DEPTH=4)
//  1. Hold A=B=1 through reset and 20 cycles after -> o_position=0, o_error=0, no strobe (PRIME absorbs initial state).
//  2. Forward sequence, 8 edges, each level held 20 cycles, enable=1 -> o_position=8, o_direction=1, 8 strobes,
//     o_step_period=20, o_period_valid=1; repeat with i_invert_dir=1 -> o_position=0.
//  3. A glitch high for 3 cycles (< FILTER_DEPTH) -> no strobe, position unchanged; 4-cycle pulse -> counts +1 then -1.
//  4. Jump 00->11 -> o_error=1, position unchanged; i_clear pulse -> o_error=0; reversal edge -> o_period_valid=0.
//  5. Load 0xFFFFFFFF, then one forward edge -> o_position=0; load 0x100 in the same cycle as an edge -> 0x100, strobe=1.
//  6. Index pulse at position 5 -> o_index_position=5, o_index_seen=1; idle TIMEOUT_CYCLES -> o_stalled=1, valid=0.

Source files
------------

// File: rtl/quadrature_position_decoder.sv
`default_nettype none
// quadrature_position_decoder: synchronizes and glitch-filters encoder A/B/index, 4x-decodes
// into a wrapping 32-bit position and measures the same-direction inter-edge period.
module quadrature_position_decoder #(
  parameter int unsigned FILTER_DEPTH   = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enc_a,
  input  logic        i_enc_b,
  input  logic        i_enc_index,
  input  logic        i_enable,
  input  logic        i_invert_dir,
  input  logic        i_load,
  input  logic [31:0] i_load_position,
  input  logic        i_clear,
  output logic [31:0] o_position,
  output logic        o_direction,
  output logic        o_step_strobe,
  output logic [31:0] o_step_period,
  output logic        o_period_valid,
  output logic        o_stalled,
  output logic [31:0] o_index_position,
  output logic        o_index_seen,
  output logic        o_error
);

  localparam int unsigned    CW       = (FILTER_DEPTH < 1) ? 1 : $clog2(FILTER_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH    = CW'(FILTER_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(FILTER_DEPTH - 1);

  typedef enum logic [0:0] {PRIME = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_next;

  logic [2:0] pins;
  logic [2:0] sync_meta;
  logic [2:0] sync_q;
  logic [2:0] filt;
  logic [2:0] stable;

  assign pins = {i_enc_index, i_enc_a, i_enc_b};

  // Synchronizers are left unreset so they already hold the pin levels when rst releases.
  always_ff @(posedge clk) begin
    sync_meta <= pins;
    sync_q    <= sync_meta;
  end

  for (genvar g = 0; g < 3; g++) begin : g_chan
    logic          filt_bit;
    logic [CW-1:0] glitch_cnt;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        filt_bit   <= 1'b0;
        glitch_cnt <= '0;
        stable_cnt <= '0;
      end else if (sync_q[g] == filt_bit) begin
        glitch_cnt <= '0;
        if (stable_cnt != DEPTH) stable_cnt <= stable_cnt + CW'(1);
      end else begin
        stable_cnt <= '0;
        if (glitch_cnt == DEPTH_M1) begin
          filt_bit   <= sync_q[g];
          glitch_cnt <= '0;
        end else begin
          glitch_cnt <= glitch_cnt + CW'(1);
        end
      end
    end

    assign filt[g]   = filt_bit;
    assign stable[g] = (stable_cnt == DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= PRIME;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == PRIME && (&stable)) state_next = RUN;
  end

  function automatic logic [1:0] phase_of(input logic [1:0] ab_v);
    case (ab_v)
      2'b00:   phase_of = 2'd0;
      2'b10:   phase_of = 2'd1;
      2'b11:   phase_of = 2'd2;
      default: phase_of = 2'd3;
    endcase
  endfunction

  logic [1:0]  ab;
  logic [1:0]  prev_ab;
  logic        prev_index;
  logic        run;
  logic        edge_valid;
  logic        edge_illegal;
  logic        pos_dir;
  logic        counted;
  logic        index_rise;
  logic        have_dir;
  logic [31:0] period_cnt;
  logic [31:0] pos_next;

  // prev_* follows the filters in every state, so PRIME absorbs the initial levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab    <= 2'b00;
      prev_index <= 1'b0;
    end else begin
      prev_ab    <= ab;
      prev_index <= filt[2];
    end
  end

  assign ab           = filt[1:0];
  assign run          = (state == RUN);
  assign edge_illegal = run && (&(ab ^ prev_ab));
  assign edge_valid   = run && (ab != prev_ab) && !(&(ab ^ prev_ab));
  assign pos_dir      = ((phase_of(ab) - phase_of(prev_ab)) == 2'd1) ^ i_invert_dir;
  assign counted      = edge_valid && i_enable;
  assign index_rise   = run && i_enable && filt[2] && !prev_index;
  assign o_stalled    = (period_cnt == TIMEOUT_CYCLES);

  always_comb begin
    pos_next = o_position;
    if (i_load)       pos_next = i_load_position;
    else if (counted) pos_next = pos_dir ? (o_position + 32'd1) : (o_position - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_position       <= 32'd0;
      o_direction      <= 1'b0;
      o_step_strobe    <= 1'b0;
      o_step_period    <= 32'd0;
      o_period_valid   <= 1'b0;
      o_index_position <= 32'd0;
      o_index_seen     <= 1'b0;
      o_error          <= 1'b0;
      period_cnt       <= 32'd0;
      have_dir         <= 1'b0;
    end else begin
      o_position    <= pos_next;
      o_step_strobe <= counted;

      if (i_clear) begin
        o_error      <= 1'b0;
        o_index_seen <= 1'b0;
      end
      if (edge_illegal) o_error <= 1'b1;
      if (index_rise) begin
        o_index_seen     <= 1'b1;
        o_index_position <= pos_next;
      end

      // Period is only meaningful between two unsaturated same-direction edges.
      if (!i_enable) begin
        period_cnt     <= 32'd0;
        o_period_valid <= 1'b0;
        have_dir       <= 1'b0;
      end else if (counted) begin
        if (have_dir && !o_stalled && (pos_dir == o_direction)) begin
          o_step_period  <= period_cnt + 32'd1;
          o_period_valid <= 1'b1;
        end else begin
          o_period_valid <= 1'b0;
        end
        o_direction <= pos_dir;
        have_dir    <= 1'b1;
        period_cnt  <= 32'd0;
      end else if (o_stalled) begin
        o_period_valid <= 1'b0;
      end else begin
        period_cnt <= period_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quadrature_position_decoder.sv
`default_nettype none
// tb_quadrature_position_decoder: directed plus randomized encoder stimulus checked against a
// phase-level model of position, strobe count, direction, period and sticky flags.
module tb_quadrature_position_decoder;

  localparam logic [31:0] TIMEOUT = 32'd2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enc_a, i_enc_b, i_enc_index;
  logic        i_enable, i_invert_dir, i_load, i_clear;
  logic [31:0] i_load_position;
  logic [31:0] o_position, o_step_period, o_index_position;
  logic        o_direction, o_step_strobe, o_period_valid, o_stalled, o_index_seen, o_error;

  quadrature_position_decoder #(.FILTER_DEPTH(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_enc_a(i_enc_a), .i_enc_b(i_enc_b), .i_enc_index(i_enc_index),
    .i_enable(i_enable), .i_invert_dir(i_invert_dir), .i_load(i_load),
    .i_load_position(i_load_position), .i_clear(i_clear), .o_position(o_position),
    .o_direction(o_direction), .o_step_strobe(o_step_strobe), .o_step_period(o_step_period),
    .o_period_valid(o_period_valid), .o_stalled(o_stalled), .o_index_position(o_index_position),
    .o_index_seen(o_index_seen), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobes = 0;
  int exp_strobes = 0;
  int phase = 2;
  int last_edge = 0;
  bit have_prev = 0;
  bit exp_dir = 0;
  bit exp_valid = 0;
  bit exp_seen = 0;
  bit exp_err = 0;
  logic [31:0] exp_pos = 0;
  logic [31:0] exp_period = 0;
  logic [31:0] exp_idx = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_step_strobe) strobes++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Quadrature pin levels for phase 0..3: 00, 10, 11, 01 as {A,B}.
  task automatic drive_phase();
    case (phase)
      0: begin i_enc_a = 1'b0; i_enc_b = 1'b0; end
      1: begin i_enc_a = 1'b1; i_enc_b = 1'b0; end
      2: begin i_enc_a = 1'b1; i_enc_b = 1'b1; end
      default: begin i_enc_a = 1'b0; i_enc_b = 1'b1; end
    endcase
  endtask

  task automatic step_drive(input int dir);
    bit eff;
    phase = (phase + dir + 4) % 4;
    drive_phase();
    if (i_enable) begin
      eff = (dir > 0) ^ i_invert_dir;
      exp_pos = exp_pos + (eff ? 32'd1 : 32'hFFFF_FFFF);
      exp_strobes++;
      if (have_prev && eff == exp_dir && (cyc - last_edge) <= int'(TIMEOUT)) begin
        exp_period = 32'(cyc - last_edge);
        exp_valid  = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      exp_dir   = eff;
      have_prev = 1'b1;
      last_edge = cyc;
    end
  endtask

  task automatic step(input int dir, input int hold);
    step_drive(dir);
    repeat (hold) tick();
  endtask

  task automatic glitch_a(input int len);
    i_enc_a = ~i_enc_a;
    repeat (len) tick();
    i_enc_a = ~i_enc_a;
    repeat (10) tick();
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pos"}, o_position, exp_pos);
    chk({tag, ".strobes"}, 32'(strobes), 32'(exp_strobes));
    chk({tag, ".dir"}, {31'd0, o_direction}, {31'd0, exp_dir});
    chk({tag, ".valid"}, {31'd0, o_period_valid}, {31'd0, exp_valid});
    chk({tag, ".period"}, o_step_period, exp_period);
    chk({tag, ".err"}, {31'd0, o_error}, {31'd0, exp_err});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_enable = 1'b1; i_invert_dir = 1'b0; i_load = 1'b0; i_clear = 1'b0;
    i_load_position = 32'd0; i_enc_index = 1'b0;
    drive_phase();
    repeat (5) tick();
    chk("reset.pos", o_position, 32'd0);
    chk("reset.flags", {26'd0, o_direction, o_step_strobe, o_period_valid, o_stalled,
                        o_index_seen, o_error}, 32'd0);
    chk("reset.period", o_step_period, 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    chk_all("prime");

    for (int i = 0; i < 8; i++) step(1, 20);
    chk_all("fwd8");
    chk("fwd8.period20", o_step_period, 32'd20);
    i_invert_dir = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 20);
    chk_all("inv8");
    chk("inv8.zero", o_position, 32'd0);

    i_invert_dir = 1'b0;
    glitch_a(3);
    chk_all("glitch3");
    step(1, 4);
    step(-1, 12);
    chk_all("pulse4");

    step(1, 15);
    step(1, 15);
    phase = (phase + 2) % 4;
    drive_phase();
    exp_err = 1'b1;
    repeat (12) tick();
    chk_all("jump");
    i_clear = 1'b1; tick(); i_clear = 1'b0; exp_err = 1'b0;
    tick();
    chk_all("clear");
    step(-1, 15);
    chk_all("reversal");
    chk("reversal.invalid", {31'd0, o_period_valid}, 32'd0);

    i_load = 1'b1; i_load_position = 32'hFFFF_FFFF; tick(); i_load = 1'b0;
    exp_pos = 32'hFFFF_FFFF;
    chk("load.max", o_position, exp_pos);
    step(1, 12);
    chk_all("wrap");
    step_drive(1);
    repeat (6) tick();
    i_load = 1'b1; i_load_position = 32'h100; tick(); i_load = 1'b0;
    exp_pos = 32'h100;
    chk("loadedge.strobe", {31'd0, o_step_strobe}, 32'd1);
    repeat (8) tick();
    chk_all("loadedge");

    i_enable = 1'b0; have_prev = 1'b0; exp_valid = 1'b0;
    tick();
    step(1, 12);
    step(1, 12);
    chk_all("disabled");
    i_enable = 1'b1;
    repeat (10) tick();
    chk_all("reenable");
    step(1, 15);
    step(1, 15);
    chk_all("reenable.count");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) i_invert_dir = ~i_invert_dir;
      step(($urandom_range(0, 1) != 0) ? 1 : -1, $urandom_range(8, 30));
      if ($urandom_range(0, 3) == 0) glitch_a($urandom_range(1, 3));
      chk_all("rand");
    end

    i_load = 1'b1; i_load_position = 32'd5; tick(); i_load = 1'b0;
    exp_pos = 32'd5;
    i_enc_index = 1'b1; repeat (10) tick(); i_enc_index = 1'b0; repeat (10) tick();
    exp_idx = exp_pos; exp_seen = 1'b1;
    chk("index.pos", o_index_position, exp_idx);
    chk("index.seen", {31'd0, o_index_seen}, {31'd0, exp_seen});
    i_clear = 1'b1; tick(); i_clear = 1'b0; exp_seen = 1'b0;
    tick();
    chk("index.clear", {31'd0, o_index_seen}, {31'd0, exp_seen});

    repeat (int'(TIMEOUT) + 100) tick();
    exp_valid = 1'b0;
    chk("stall.on", {31'd0, o_stalled}, 32'd1);
    chk_all("stall");
    step(1, 20);
    chk("stall.off", {31'd0, o_stalled}, 32'd0);
    chk_all("stall.edge1");
    step(1, 20);
    chk_all("stall.edge2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
